// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier.
// Handles signed (tc=1) and unsigned (tc=0) operands through one datapath.
// Both operands are extended by one bit, so unsigned values become
// non-negative signed values and a single signed Booth loop covers both modes.
// It runs WIDTH+1 Booth steps, one per clock, and gives a fixed,
// data-independent latency.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; product holds the last result
// CALC  | one Booth step per clock, WIDTH+1 steps in all; busy high
// DONE  | product just updated; done high for this one cycle
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int AW = WIDTH + 2;            // accumulator: headroom so add/sub never overflows
  localparam int QW = WIDTH + 1;            // extended multiplier
  localparam int CW = $clog2(WIDTH + 2);    // holds iteration count WIDTH..0

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  mcand;
  logic [QW-1:0]  q;
  logic           qm1;
  logic [CW-1:0]  cnt;

  logic [QW-1:0]  a_ext;
  logic [QW-1:0]  b_ext;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  acc_nx;
  logic [QW-1:0]  q_nx;

  // Operand extension by one bit: sign bit when two's complement, zero otherwise.
  always_comb begin
    a_ext = tc ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext = tc ? {b[WIDTH-1], b} : {1'b0, b};
  end

  // One Booth step: recode {Q0, Q-1}, add/sub multiplicand, arithmetic shift right.
  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nx = {sum[AW-1], sum[AW-1:1]};
    q_nx   = {sum[0], q[QW-1:1]};
  end

  // Control FSM and datapath registers; outputs are registered here as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= '0;
            mcand <= {a_ext[QW-1], a_ext};
            q     <= b_ext;
            qm1   <= 1'b0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_nx;
          q   <= q_nx;
          qm1 <= q[0];
          if (cnt == '0) begin
            // Last step: the product is taken straight from the post-shift value.
            product <= {acc_nx[WIDTH-2:0], q_nx};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq (WIDTH=8).
// Expected products are queued when an operation is launched, and are
// popped and compared when done appears.
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           tc;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .tc(tc),
    .a(a), .b(b), .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic t, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    int px, py, p;
    if (t) begin
      px = $signed(x);
      py = $signed(y);
    end else begin
      px = int'(x);
      py = int'(y);
    end
    p = px * py;
    return p[2*W-1:0];
  endfunction

  // Called at a falling edge; returns at the falling edge inside the done cycle.
  // The capture edge counts as cycle 1, so done is expected at cycle W+2.
  task automatic run_op(input logic t, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int glitch_at);
    int cyc;
    bit busy_ok;
    logic [2*W-1:0] e;
    start = 1'b1; tc = t; a = x; b = y;
    exp_q.push_back(ref_mul(t, x, y));
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); tc = 1'($urandom);
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == glitch_at) begin
        start = 1'b1; a = ~x; b = y + 8'd1; tc = ~t;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL busy_in_calc t=%0d a=%h b=%h: busy dropped before done", t, x, y);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout t=%0d a=%h b=%h: done=%b after %0d cycles", t, x, y, done, cyc);
    end
    checks++;
    if (cyc !== W + 2) begin
      errors++;
      $display("FAIL latency t=%0d a=%h b=%h: got %0d cycles, need %0d", t, x, y, cyc, W + 2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_with_done t=%0d a=%h b=%h: busy=%b, need 0", t, x, y, busy);
    end
    e = exp_q.pop_front();
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL product t=%0d a=%h b=%h: got %h, need %h", t, x, y, product, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tc = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: product=%h busy=%b done=%b, need 0/0/0", product, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(1'b1, 8'h80, 8'h80, 0);          // -128 * -128 = 16384
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 16'h4000 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold: product=%h done=%b busy=%b, need 4000/0/0", product, done, busy);
    end
    run_op(1'b1, 8'h7F, 8'h80, 0);          // 127 * -128 = -16256
    @(negedge clk);
    run_op(1'b0, 8'hFF, 8'hFF, 0);          // 255 * 255 = 65025
    @(negedge clk);
    run_op(1'b0, 8'h00, 8'hA5, 0);          // zero multiplicand
    @(negedge clk);
    run_op(1'b1, 8'hFF, 8'h01, 0);          // -1 * 1
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    bit extra;
    run_op(1'b1, 8'h64, 8'hDB, 4);          // 100 * -37, start pulsed mid-CALC
    extra = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL ignore_start: extra done/busy after first result (done=%b busy=%b)", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start = 1'b1; tc = 1'b1; a = 8'h33; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);              // now in CALC iteration 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h, need 0/0/0000", busy, done, product);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_done: aborted op raised done (got 1, need 0)");
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 8'h80, 8'h7F, 0);
    run_op(1'b0, 8'hC3, 8'h5A, 0);          // start held in the DONE cycle
    run_op(1'b1, 8'hF0, 8'h0F, 0);
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [W-1:0] vals[12];
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7E, 8'h7F,
             8'h80, 8'h81, 8'hAA, 8'h55, 8'hFE, 8'hFF};
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          run_op(t[0], vals[i], vals[j], 0);
          @(negedge clk);
        end
      end
    end
    for (int k = 0; k < 40; k++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
